// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response bus between a requester and mem_ctrl.
//
// Handshake: a request is accepted on a rising clk edge where req=1 and
// ready=1; wr/addr/wdata/be are sampled on that same edge. req is ignored
// while ready=0 (no queuing). Every accepted request produces exactly one
// one-cycle rvalid strobe; rdata and err are meaningful only while rvalid=1.
//
// Signals:
//   req, wr, addr[31:0], wdata[DATA_W-1:0], be[NB-1:0]  requester -> controller
//   ready, rvalid, rdata[DATA_W-1:0], err               controller -> requester
// Modports: master (requester side), slave (controller side).
interface mem_ctrl_if #(
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              req;
    logic              wr;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     be;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, wr, addr, wdata, be,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, wr, addr, wdata, be,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port word memory behind a request/response handshake with
// a fixed, programmable access latency and byte-lane write enables.
//
// Parameters: DATA_W (multiple of 8, 8..64), DEPTH (words), WAIT_CYCLES (0..15).
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        mem_ctrl_if.slave (req/wr/addr/wdata/be in; ready/rvalid/rdata/err out)
//   dbg_state  current FSM state (0=IDLE, 1=WAIT, 2=RESP)
// Build option: MEM_RESET_CLEAR_EN -- when defined, rst also clears every
// array word; when undefined the array has no reset and maps to plain RAM.
module mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    mem_ctrl_if.slave   bus,
    output logic [1:0]  dbg_state
);
    localparam int NB  = DATA_W / 8;
    localparam int OFS = (NB > 1) ? $clog2(NB) : 0;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, next_state;
    logic [3:0]        cnt;
    logic              lat_wr;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [NB-1:0]     lat_be;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // Access currently being completed. With WAIT_CYCLES=0 the controller
    // goes straight from IDLE to RESP, so the request must be taken from the
    // bus on that edge rather than from the latch being loaded on it.
    logic              acc_wr;
    logic [31:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [NB-1:0]     acc_be;
    logic [31:0]       word_idx;
    logic [AW-1:0]     acc_idx;
    logic              addr_err;
    logic              enter_resp;
    logic              mem_we;

    always_comb begin
        acc_wr    = lat_wr;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_be    = lat_be;
        if (state == IDLE) begin
            acc_wr    = bus.wr;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
            acc_be    = bus.be;
        end
        word_idx = acc_addr >> OFS;
        acc_idx  = word_idx[AW-1:0];
        addr_err = (word_idx >= 32'(DEPTH)) || ((acc_addr & 32'(NB - 1)) != 32'd0);
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.req) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT: if (cnt <= 4'd1) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign enter_resp = (next_state == RESP) && (state != RESP);
    assign mem_we     = enter_resp && acc_wr && !addr_err && !rst;

    assign bus.ready  = (state == IDLE);
    assign bus.rvalid = (state == RESP);
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_wr    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && bus.req) begin
                lat_wr    <= bus.wr;
                lat_addr  <= bus.addr;
                lat_wdata <= bus.wdata;
                lat_be    <= bus.be;
                if (WAIT_CYCLES > 0) cnt <= 4'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            // Response registers are non-zero only during the RESP cycle.
            rdata_q <= '0;
            err_q   <= 1'b0;
            if (enter_resp) begin
                err_q <= addr_err;
                if (!acc_wr && !addr_err) rdata_q <= mem[acc_idx];
            end
        end
    end

`ifdef MEM_RESET_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            for (int i = 0; i < NB; i++)
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++)
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
    end
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  dbg, dbg0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    mem_ctrl_if #(.DATA_W(32)) bus ();
    mem_ctrl_if #(.DATA_W(32)) bus0 ();

    mem_ctrl #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg)
    );
    mem_ctrl #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0)
    );

    // Drives one access on bus and reports what came back.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, output logic [31:0] rd, output logic e,
                             output int lat, output int rv_cyc, output logic rv_after);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d; bus.be = b;
        @(posedge clk); #1;
        bus.req = 1'b0;
        lat = 1;
        while (bus.rvalid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        rd = bus.rdata; e = bus.err; rv_cyc = cyc;
        @(posedge clk); #1;
        rv_after = bus.rvalid;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", bus.rvalid); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        checks++; if (dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", bus.ready); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic e; int lat, rc, t0; logic ra;
        t0 = cyc;
        do_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat, rc, ra);
        checks++; if (rc - t0 !== 3) begin errors++; $display("FAIL wr_rvalid_cycle: got %0d expected 3", rc - t0); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h expected 0", rd); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL wr_rvalid_width: got %b expected 0", ra); end
        do_access(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, rc, ra);
        checks++; if (rc - t0 !== 7) begin errors++; $display("FAIL rd_rvalid_cycle: got %0d expected 7", rc - t0); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", e); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rdata_idle: got %h expected 0", bus.rdata); end
    endtask

    task automatic test_partial_write();
        logic [31:0] rd, exp; logic e; int lat, rc; logic ra;
        do_access(1'b1, 32'h10, 32'h11223344, 4'h5, rd, e, lat, rc, ra);
        exp_q.push_back(32'hDE22BE44);
        do_access(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, e, lat, rc, ra);
        checks++; if (lat !== 3) begin errors++; $display("FAIL be0_latency: got %0d expected 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL be0_err: got %b expected 0", e); end
        exp_q.push_back(32'hDE22BE44);
        repeat (2) begin
            do_access(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, rc, ra);
            exp = exp_q.pop_front();
            checks++; if (rd !== exp) begin errors++; $display("FAIL partial_rdata: got %h expected %h", rd, exp); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat, rc; logic ra;
        do_access(1'b0, 32'h100, 32'h0, 4'h0, rd, e, lat, rc, ra);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oob_err: got %b expected 1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oob_rdata: got %h expected 0", rd); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL oob_rvalid_width: got %b expected 0", ra); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL oob_latency: got %0d expected 3", lat); end
        do_access(1'b1, 32'h12, 32'h0, 4'hF, rd, e, lat, rc, ra);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b expected 1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_rdata: got %h expected 0", rd); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL misalign_rvalid_width: got %b expected 0", ra); end
        do_access(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, rc, ra);
        checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL err_no_change: got %h expected de22be44", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL good_after_err: got %b expected 0", e); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic e; int lat, rc, seen; logic ra;
        logic [31:0] exp10, exp20;
        do_access(1'b1, 32'h20, 32'h12345678, 4'hF, rd, e, lat, rc, ra);
        bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 32'h10; bus.wdata = 32'h55667788; bus.be = 4'hF;
        @(posedge clk); #1;
        bus.req = 1'b0;
        checks++; if (dbg !== 2'd1) begin errors++; $display("FAIL abort_in_wait: got %0d expected 1", dbg); end
        rst = 1'b1;
        #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", bus.ready); end
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL abort_rvalid: got %b expected 0", bus.rvalid); end
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.rvalid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_resp: got %0d responses expected 0", seen); end
`ifdef MEM_RESET_CLEAR_EN
        exp10 = 32'h0; exp20 = 32'h0;
`else
        exp10 = 32'hDE22BE44; exp20 = 32'h12345678;
`endif
        do_access(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, rc, ra);
        checks++; if (rd !== exp10) begin errors++; $display("FAIL abort_word10: got %h expected %h", rd, exp10); end
        do_access(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat, rc, ra);
        checks++; if (rd !== exp20) begin errors++; $display("FAIL reset_word20: got %h expected %h", rd, exp20); end
    endtask

    task automatic test_back_to_back();
        logic exp_rv;
        bus0.req = 1'b1; bus0.wr = 1'b1; bus0.addr = 32'h8; bus0.wdata = 32'hCAFEF00D; bus0.be = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            exp_rv = ((i % 2) == 0);
            checks++; if (bus0.rvalid !== exp_rv) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b expected %b", i, bus0.rvalid, exp_rv); end
            checks++; if (bus0.ready !== !exp_rv) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, bus0.ready, !exp_rv); end
            if (exp_rv) begin
                checks++; if (bus0.err !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d]: got %b expected 0", i, bus0.err); end
            end
        end
        bus0.wr = 1'b0;
        @(posedge clk); #1;
        bus0.req = 1'b0;
        checks++; if (bus0.rvalid !== 1'b1) begin errors++; $display("FAIL w0_rd_rvalid: got %b expected 1", bus0.rvalid); end
        checks++; if (bus0.rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL w0_rd_data: got %h expected cafef00d", bus0.rdata); end
    endtask

    initial begin
        bus.req = 1'b0; bus.wr = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0; bus.be = 4'h0;
        bus0.req = 1'b0; bus0.wr = 1'b0; bus0.addr = 32'h0; bus0.wdata = 32'h0; bus0.be = 4'h0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
